// File: rtl/exec_unit_pipe_if.sv
// rtl/exec_unit_pipe_if.sv - uop issue and result handshake bundle for exec_unit_pipe
// master is the issuing/write-back side, slave is the execution unit.
interface exec_unit_pipe_if #(
   parameter int DATA_WIDTH = 32,
   parameter int IMM_WIDTH  = 21
);
   logic                  in_valid;
   logic                  in_ready;
   logic [6:0]            instruction_type;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [IMM_WIDTH-1:0]  immediate;
   logic [DATA_WIDTH-1:0] data_src1;
   logic [DATA_WIDTH-1:0] data_src2;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] Execution_Result;
   logic                  out_illegal;

   modport master (
      output in_valid, instruction_type, funct3, funct7, immediate,
             data_src1, data_src2, out_ready,
      input  in_ready, out_valid, Execution_Result, out_illegal
   );

   modport slave (
      input  in_valid, instruction_type, funct3, funct7, immediate,
             data_src1, data_src2, out_ready,
      output in_ready, out_valid, Execution_Result, out_illegal
   );
endinterface

// File: rtl/exec_unit_pipe.sv
// rtl/exec_unit_pipe.sv - RV32I integer execute stage with iterative shift-add MUL
// Single-cycle ALU ops complete the cycle after accept; MUL runs one bit per cycle.
module exec_unit_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int IMM_WIDTH  = 21,
   parameter bit MUL_EN     = 1'b1
) (
   input logic             clk,
   input logic             reset,
   exec_unit_pipe_if.slave io
);
   localparam int SHW = $clog2(DATA_WIDTH);
   localparam int CW  = SHW + 1;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] OPC_OPI = 7'b0010011;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
   logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic                  out_valid_q, out_valid_d;
   logic                  illegal_q, illegal_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;

   logic [DATA_WIDTH-1:0] imm_ext;
   logic [DATA_WIDTH-1:0] op_b;
   logic [SHW-1:0]        shamt;
   logic [DATA_WIDTH-1:0] alu_res;
   logic [DATA_WIDTH-1:0] acc_sum;
   logic                  is_op, is_opi, is_mul, legal;
   logic                  out_free, accept, last_iter;

   generate
      if (IMM_WIDTH >= DATA_WIDTH) begin : g_imm_trunc
         assign imm_ext = io.immediate[DATA_WIDTH-1:0];
      end else begin : g_imm_sext
         assign imm_ext = {{(DATA_WIDTH-IMM_WIDTH){io.immediate[IMM_WIDTH-1]}}, io.immediate};
      end
   endgenerate

   assign is_op    = (io.instruction_type == OPC_OP);
   assign is_opi   = (io.instruction_type == OPC_OPI);
   assign op_b     = is_opi ? imm_ext : io.data_src2;
   assign shamt    = op_b[SHW-1:0];
   assign out_free = !out_valid_q || io.out_ready;
   assign io.in_ready = reset && (state_q == ST_IDLE) && out_free;
   assign accept   = io.in_valid && io.in_ready;
   assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign last_iter = (count_q == CW'(DATA_WIDTH - 1));

   // OP-IMM funct7 carries immediate bits, so only the shift forms constrain it.
   always_comb begin
      legal  = 1'b0;
      is_mul = 1'b0;
      if (is_op) begin
         case (io.funct7)
            F7_BASE: legal = 1'b1;
            F7_ALT:  legal = (io.funct3 == 3'b000) || (io.funct3 == 3'b101);
            F7_MUL: begin
               is_mul = MUL_EN && (io.funct3 == 3'b000);
               legal  = is_mul;
            end
            default: legal = 1'b0;
         endcase
      end else if (is_opi) begin
         case (io.funct3)
            3'b001:  legal = (io.funct7 == F7_BASE);
            3'b101:  legal = (io.funct7 == F7_BASE) || (io.funct7 == F7_ALT);
            default: legal = 1'b1;
         endcase
      end
   end

   always_comb begin
      alu_res = '0;
      case (io.funct3)
         3'b000: alu_res = (is_op && io.funct7[5]) ? (io.data_src1 - op_b)
                                                   : (io.data_src1 + op_b);
         3'b001: alu_res = io.data_src1 << shamt;
         3'b010: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(io.data_src1) < $signed(op_b))};
         3'b011: alu_res = {{(DATA_WIDTH-1){1'b0}}, (io.data_src1 < op_b)};
         3'b100: alu_res = io.data_src1 ^ op_b;
         3'b101: alu_res = io.funct7[5] ? DATA_WIDTH'($signed(io.data_src1) >>> shamt)
                                        : (io.data_src1 >> shamt);
         3'b110: alu_res = io.data_src1 | op_b;
         3'b111: alu_res = io.data_src1 & op_b;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q && !io.out_ready;
      result_d    = result_q;
      illegal_d   = illegal_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_mul) begin
                  mcand_d  = io.data_src1;
                  mplier_d = io.data_src2;
                  acc_d    = '0;
                  count_d  = '0;
                  state_d  = ST_BUSY;
               end else begin
                  out_valid_d = 1'b1;
                  result_d    = legal ? alu_res : '0;
                  illegal_d   = !legal;
               end
            end
         end
         ST_BUSY: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            // The final iteration's sum goes straight to the output when it is free.
            if (last_iter) begin
               if (out_free) begin
                  out_valid_d = 1'b1;
                  result_d    = acc_sum;
                  illegal_d   = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (out_free) begin
               out_valid_d = 1'b1;
               result_d    = acc_q;
               illegal_d   = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         illegal_q   <= illegal_d;
      end
   end

   assign io.out_valid        = out_valid_q;
   assign io.Execution_Result = result_q;
   assign io.out_illegal      = illegal_q;
endmodule

// File: tb/tb_exec_unit_pipe.sv
// tb/tb_exec_unit_pipe.sv - directed self-checking bench for exec_unit_pipe
// u_dut has MUL enabled; u_nomul checks MUL encodings are rejected when disabled.
module tb_exec_unit_pipe;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   busy_ok;
   int   stale;

   exec_unit_pipe_if #(.DATA_WIDTH(32), .IMM_WIDTH(21)) a_if ();
   exec_unit_pipe_if #(.DATA_WIDTH(32), .IMM_WIDTH(21)) b_if ();

   exec_unit_pipe #(.DATA_WIDTH(32), .IMM_WIDTH(21), .MUL_EN(1'b1)) u_dut (
      .clk   (clk),
      .reset (reset),
      .io    (a_if)
   );

   exec_unit_pipe #(.DATA_WIDTH(32), .IMM_WIDTH(21), .MUL_EN(1'b0)) u_nomul (
      .clk   (clk),
      .reset (reset),
      .io    (b_if)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP  = 7'b0110011;
   localparam logic [6:0] OPI = 7'b0010011;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a uop on a_if and advance to the next falling edge.
   task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [20:0] imm, input logic [31:0] s1, input logic [31:0] s2);
      a_if.instruction_type = opc;
      a_if.funct3           = f3;
      a_if.funct7           = f7;
      a_if.immediate        = imm;
      a_if.data_src1        = s1;
      a_if.data_src2        = s2;
      a_if.in_valid         = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
      a_if.instruction_type = '0; a_if.funct3 = '0; a_if.funct7 = '0;
      a_if.immediate = '0; a_if.data_src1 = '0; a_if.data_src2 = '0;
      b_if.in_valid = 1'b0; b_if.out_ready = 1'b1;
      b_if.instruction_type = '0; b_if.funct3 = '0; b_if.funct7 = '0;
      b_if.immediate = '0; b_if.data_src1 = '0; b_if.data_src2 = '0;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(a_if.in_ready), 32'd0);
      chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
      chk("rst_result", a_if.Execution_Result, 32'h0);
      chk("rst_illegal", 32'(a_if.out_illegal), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(a_if.in_ready), 32'd1);

      // Back-to-back single-cycle ops, one per cycle.
      issue(OP, 3'b000, 7'b0000000, 21'd0, 32'd5, 32'd7);
      chk("add_valid", 32'(a_if.out_valid), 32'd1);
      chk("add_result", a_if.Execution_Result, 32'h0000000C);
      chk("add_illegal", 32'(a_if.out_illegal), 32'd0);
      issue(OP, 3'b000, 7'b0100000, 21'd0, 32'd3, 32'd5);
      chk("sub_result", a_if.Execution_Result, 32'hFFFFFFFE);
      issue(OPI, 3'b101, 7'b0100000, 21'd4, 32'h80000000, 32'h0);
      chk("srai_result", a_if.Execution_Result, 32'hF8000000);
      issue(OP, 3'b101, 7'b0000000, 21'd0, 32'h80000000, 32'd4);
      chk("srl_result", a_if.Execution_Result, 32'h08000000);
      issue(OP, 3'b010, 7'b0000000, 21'd0, 32'hFFFFFFFF, 32'd1);
      chk("slt_result", a_if.Execution_Result, 32'h1);
      issue(OP, 3'b011, 7'b0000000, 21'd0, 32'hFFFFFFFF, 32'd1);
      chk("sltu_result", a_if.Execution_Result, 32'h0);
      issue(OPI, 3'b001, 7'b0000000, 21'd31, 32'h1, 32'h0);
      chk("slli_result", a_if.Execution_Result, 32'h80000000);
      issue(OP, 3'b111, 7'b0000000, 21'd0, 32'h0000F0F0, 32'h0000FF00);
      chk("and_result", a_if.Execution_Result, 32'h0000F000);
      issue(OP, 3'b100, 7'b0000000, 21'd0, 32'h0000F0F0, 32'h0000FF00);
      chk("xor_result", a_if.Execution_Result, 32'h00000FF0);
      issue(7'b0000011, 3'b000, 7'b0000000, 21'd0, 32'd5, 32'd7);
      chk("ill_opc_valid", 32'(a_if.out_valid), 32'd1);
      chk("ill_opc_flag", 32'(a_if.out_illegal), 32'd1);
      chk("ill_opc_result", a_if.Execution_Result, 32'h0);
      issue(OP, 3'b001, 7'b0000001, 21'd0, 32'd5, 32'd7);
      chk("mulh_illegal", 32'(a_if.out_illegal), 32'd1);
      issue(OP, 3'b110, 7'b0000000, 21'd0, 32'h00F0, 32'h000F);
      chk("or_result", a_if.Execution_Result, 32'h000000FF);
      chk("or_illegal", 32'(a_if.out_illegal), 32'd0);
      a_if.in_valid = 1'b0;
      @(negedge clk);
      chk("drain_valid", 32'(a_if.out_valid), 32'd0);

      // Backpressure: second uop waits until write-back consumes the first.
      a_if.out_ready = 1'b0;
      issue(OPI, 3'b000, 7'b1111111, 21'h1FFFFF, 32'd1, 32'h0);
      chk("bp_valid", 32'(a_if.out_valid), 32'd1);
      chk("bp_result", a_if.Execution_Result, 32'h0);
      a_if.funct7 = 7'b0000000; a_if.instruction_type = OP;
      a_if.data_src1 = 32'd2; a_if.data_src2 = 32'd3;
      #1;
      chk("bp_in_ready_low", 32'(a_if.in_ready), 32'd0);
      @(negedge clk);
      chk("bp_hold_valid", 32'(a_if.out_valid), 32'd1);
      chk("bp_hold_result", a_if.Execution_Result, 32'h0);
      a_if.out_ready = 1'b1;
      #1;
      chk("bp_in_ready_high", 32'(a_if.in_ready), 32'd1);
      @(negedge clk);
      chk("bp_second_valid", 32'(a_if.out_valid), 32'd1);
      chk("bp_second_result", a_if.Execution_Result, 32'h5);
      a_if.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_drain", 32'(a_if.out_valid), 32'd0);

      // MUL latency: busy for 32 cycles, product visible in N+33.
      issue(OP, 3'b000, 7'b0000001, 21'd0, 32'h0000FFFF, 32'h00010001);
      a_if.in_valid = 1'b0;
      busy_ok = 0;
      for (int i = 0; i < 32; i++) begin
         if (a_if.in_ready === 1'b0 && a_if.out_valid === 1'b0) busy_ok++;
         @(negedge clk);
      end
      chk("mul_busy_cycles", 32'(busy_ok), 32'd32);
      chk("mul_valid", 32'(a_if.out_valid), 32'd1);
      chk("mul_result", a_if.Execution_Result, 32'hFFFFFFFF);
      chk("mul_illegal", 32'(a_if.out_illegal), 32'd0);
      chk("mul_in_ready", 32'(a_if.in_ready), 32'd1);
      @(negedge clk);

      // MUL encoding on the MUL_EN=0 instance.
      b_if.instruction_type = OP; b_if.funct3 = 3'b000; b_if.funct7 = 7'b0000001;
      b_if.data_src1 = 32'd6; b_if.data_src2 = 32'd7; b_if.in_valid = 1'b1;
      @(negedge clk);
      b_if.in_valid = 1'b0;
      chk("nomul_valid", 32'(b_if.out_valid), 32'd1);
      chk("nomul_illegal", 32'(b_if.out_illegal), 32'd1);
      chk("nomul_result", b_if.Execution_Result, 32'h0);
      chk("nomul_in_ready", 32'(b_if.in_ready), 32'd1);

      // Reset ten cycles into a multiply: nothing stale may surface afterwards.
      issue(OP, 3'b000, 7'b0000001, 21'd0, 32'd3, 32'd5);
      a_if.in_valid = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rmul_valid", 32'(a_if.out_valid), 32'd0);
      chk("rmul_result", a_if.Execution_Result, 32'h0);
      chk("rmul_in_ready", 32'(a_if.in_ready), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rmul_in_ready_after", 32'(a_if.in_ready), 32'd1);
      stale = 0;
      repeat (40) begin
         if (a_if.out_valid !== 1'b0) stale++;
         @(negedge clk);
      end
      chk("rmul_no_stale", 32'(stale), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
